keypad_scan: RTL and testbench

Matrix-keypad scanner and debouncer that is the input side of the passcode lock. It drives the rows of a 4x3 telephone keypad and samples its columns. Each debounced key press becomes one single-cycle strobe on a one-hot digit bus `a[0:9]`, or on `enter` or `clr`. Optionally it echoes the last digit on a 7-segment output.

---
 rtl/keypad_scan.sv | 187 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner/debouncer producing single-cycle key strobes.
// Define KEYPAD_ECHO_EN to add the active-low 7-segment last-digit echo on seg.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [0:3] row,
    input  logic [0:2] col,
    output logic [0:9] a,
    output logic       enter,
    output logic       clr
`ifdef KEYPAD_ECHO_EN
    ,
    output logic [0:6] seg
`endif
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEBOUNCE);
    localparam logic [3:0] CODE_STAR = 4'd10;
    localparam logic [3:0] CODE_HASH = 4'd11;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESS, HOLD} state_t;

    state_t           state;
    logic [0:2]       col_s1, col_s2;
    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic [1:0]       key_col;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rel_next;
    logic             sample;
    logic             one_low;
    logic [1:0]       col_idx;
    logic             fire;
    logic [3:0]       strobe_code;

    // Key codes: 0..9 digits, 10 = '*', 11 = '#'.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        if (r != 2'd3)
            return {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
        case (c)
            2'd0:    return CODE_STAR;
            2'd1:    return 4'd0;
            default: return CODE_HASH;
        endcase
    endfunction

`ifdef KEYPAD_ECHO_EN
    localparam logic [0:6] SEG_DASH = 7'b1111110;

    function automatic logic [0:6] seg_pat(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_DASH;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1 <= 3'b111;
            col_s2 <= 3'b111;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else
            div <= sample ? '0 : div + 1'b1;
    end

    assign sample = (div == DIV_LAST);
    assign row    = ~(4'b1000 >> row_idx);

    always_comb begin
        one_low = 1'b1;
        col_idx = 2'd0;
        case (col_s2)
            3'b011:  col_idx = 2'd0;
            3'b101:  col_idx = 2'd1;
            3'b110:  col_idx = 2'd2;
            default: one_low = 1'b0;
        endcase
    end

    assign cnt_inc     = cnt + 1'b1;
    assign rel_next    = (col_s2 == 3'b111) ? cnt_inc : '0;
    assign strobe_code = key_code(row_idx, col_idx);

    // The strobe is registered on the accepting sample edge, so it is high
    // exactly during the one cycle spent in PRESS.
    always_comb begin
        fire = 1'b0;
        if (sample && one_low) begin
            if (state == SCAN && DEBOUNCE == 1)
                fire = 1'b1;
            else if (state == DEB_PRESS && col_idx == key_col && cnt_inc == CNT_TGT)
                fire = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCAN;
            row_idx <= 2'd0;
            key_col <= 2'd0;
            cnt     <= '0;
            a       <= '0;
            enter   <= 1'b0;
            clr     <= 1'b0;
`ifdef KEYPAD_ECHO_EN
            seg     <= SEG_DASH;
`endif
        end else begin
            a     <= '0;
            enter <= 1'b0;
            clr   <= 1'b0;
            case (state)
                SCAN: if (sample) begin
                    if (one_low) begin
                        key_col <= col_idx;
                        cnt     <= CNT_W'(1);
                        state   <= fire ? PRESS : DEB_PRESS;
                    end else begin
                        row_idx <= row_idx + 1'b1;
                    end
                end
                DEB_PRESS: if (sample) begin
                    if (fire)
                        state <= PRESS;
                    else if (one_low && col_idx == key_col)
                        cnt <= cnt_inc;
                    else begin
                        state   <= SCAN;
                        row_idx <= row_idx + 1'b1;
                    end
                end
                PRESS: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
                HOLD: if (sample) begin
                    if (rel_next == CNT_TGT) begin
                        state   <= SCAN;
                        row_idx <= 2'd0;
                        cnt     <= '0;
                    end else begin
                        cnt <= rel_next;
                    end
                end
                default: state <= SCAN;
            endcase

            if (fire) begin
                case (strobe_code)
                    CODE_STAR: clr   <= 1'b1;
                    CODE_HASH: enter <= 1'b1;
                    default:   a     <= 10'b1000000000 >> strobe_code;
                endcase
`ifdef KEYPAD_ECHO_EN
                if (strobe_code != CODE_HASH)
                    seg <= seg_pat(strobe_code);
`endif
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized/directed bench for keypad_scan with a keypad contact model and
// an expected-strobe reference model (seg checks when KEYPAD_ECHO_EN is set).
module tb_keypad_scan;

    localparam int S = 4;
    localparam int D = 3;
    localparam int LAT_MIN = 2 + (D - 1) * S + 1;
    localparam int LAT_MAX = 2 + (D + 3) * S + 1;
    localparam logic [0:6] DASH = 7'b1111110;
    localparam logic [0:6] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                        7'b0000000, 7'b0000100};

    typedef struct {
        logic [0:9] a;
        logic       en;
        logic       cl;
        logic [0:6] seg;
        longint     t;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:3] row;
    logic [0:2] col;
    logic [0:9] a;
    logic       enter;
    logic       clr;
    logic [0:6] seg;
    logic       pad [4][3];

    int checks = 0;
    int failures = 0;
    int overlap_err = 0;
    int width_err = 0;
    int row_err = 0;
    bit prev_any = 1'b0;
    ev_t got_q[$];
    logic [0:6] exp_seg;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV(S), .DEBOUNCE(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .row   (row),
        .col   (col),
        .a     (a),
        .enter (enter),
        .clr   (clr)
`ifdef KEYPAD_ECHO_EN
        ,
        .seg   (seg)
`endif
    );

`ifndef KEYPAD_ECHO_EN
    assign seg = DASH;
`endif

    // Pressed switch shorts its column line to its row line.
    always_comb begin
        col = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pad[r][c] && !row[r]) col[c] = 1'b0;
    end

    always @(negedge clk) begin
        bit any;
        ev_t ev;
        any = (a != 0) || enter || clr;
        if (($countones(a) + int'(enter) + int'(clr)) > 1) overlap_err++;
        if (any && prev_any) width_err++;
        if (!(row inside {4'b0111, 4'b1011, 4'b1101, 4'b1110})) row_err++;
        if (any) begin
            ev.a = a; ev.en = enter; ev.cl = clr; ev.seg = seg; ev.t = $time;
            got_q.push_back(ev);
        end
        prev_any = any;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int key_row(input int code);
        if (code >= 1 && code <= 9) return (code - 1) / 3;
        return 3;
    endfunction

    function automatic int key_col(input int code);
        if (code >= 1 && code <= 9) return (code - 1) % 3;
        if (code == 0) return 1;
        return (code == 10) ? 0 : 2;
    endfunction

    // Checks the single strobe expected for one press of key `code`.
    task automatic expect_one(input string tag, input int code, input longint t_press, input bit chk_lat);
        ev_t ev;
        logic [0:9] exp_a;
        longint lat;
        exp_a = '0;
        if (code <= 9) begin
            exp_a[code] = 1'b1;
            exp_seg = PAT[code];
        end else if (code == 10) begin
            exp_seg = DASH;
        end
        check({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            ev = got_q.pop_front();
            check({tag, "_a"}, 32'(ev.a), 32'(exp_a));
            check({tag, "_enter"}, 32'(ev.en), 32'(code == 11));
            check({tag, "_clr"}, 32'(ev.cl), 32'(code == 10));
`ifdef KEYPAD_ECHO_EN
            check({tag, "_seg"}, 32'(ev.seg), 32'(exp_seg));
`endif
            if (chk_lat) begin
                lat = (ev.t - t_press) / 10;
                check({tag, "_lat_ok"}, 32'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
            end
        end
        got_q.delete();
    endtask

    task automatic press_release(input string tag, input int code, input int hold, input bit bounce);
        int r, c;
        longint tp;
        r = key_row(code);
        c = key_col(code);
        if (bounce)
            for (int i = 0; i < 10; i++) begin
                pad[r][c] = ~pad[r][c];
                repeat (3) @(negedge clk);
            end
        pad[r][c] = 1'b1;
        tp = $time;
        repeat (hold) @(negedge clk);
        if (bounce)
            for (int i = 0; i < 10; i++) begin
                pad[r][c] = ~pad[r][c];
                @(negedge clk);
            end
        pad[r][c] = 1'b0;
        repeat (40) @(negedge clk);
        expect_one(tag, code, tp, !bounce);
    endtask

    initial begin
        int seq [5] = '{2, 6, 0, 1, 11};
        logic [0:3] prev_row;
        int trans, bad, run;

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++) pad[r][c] = 1'b0;
        exp_seg = DASH;
        rst = 1'b1;
        #1;
        check("rst_row", 32'(row), 32'(4'b0111));
        check("rst_a", 32'(a), 0);
        check("rst_enter", 32'(enter), 0);
        check("rst_clr", 32'(clr), 0);
`ifdef KEYPAD_ECHO_EN
        check("rst_seg", 32'(seg), 32'(DASH));
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        press_release("hold2", 2, 300, 1'b0);
        press_release("bounce7", 7, 60, 1'b1);
        press_release("hash", 11, 50, 1'b0);
        press_release("star", 10, 50, 1'b0);

        // Two columns low in row 1: never a valid press, scanning must go on.
        pad[1][0] = 1'b1;
        pad[1][2] = 1'b1;
        prev_row = row;
        trans = 0; bad = 0; run = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            run++;
            if (row != prev_row) begin
                trans++;
                if (row != {prev_row[3], prev_row[0:2]}) bad++;
                if (trans > 1 && run != S) bad++;
                run = 0;
                prev_row = row;
            end
        end
        pad[1][0] = 1'b0;
        pad[1][2] = 1'b0;
        repeat (40) @(negedge clk);
        check("multi_no_strobe", got_q.size(), 0);
        check("multi_row_order_bad", bad, 0);
        check("multi_row_cycling", 32'(trans >= 45), 1);
        got_q.delete();

        // Reset while key 5 is in HOLD, then it must strobe once more.
        pad[1][1] = 1'b1;
        repeat (40) @(negedge clk);
        expect_one("k5_pre", 5, $time, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_row", 32'(row), 32'(4'b0111));
        check("mid_rst_a", 32'(a), 0);
        check("mid_rst_enter", 32'(enter), 0);
        check("mid_rst_clr", 32'(clr), 0);
`ifdef KEYPAD_ECHO_EN
        check("mid_rst_seg", 32'(seg), 32'(DASH));
`endif
        exp_seg = DASH;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        pad[1][1] = 1'b0;
        repeat (40) @(negedge clk);
        expect_one("k5_post", 5, $time, 1'b0);

        foreach (seq[i]) press_release($sformatf("seq%0d", i), seq[i], 50, 1'b0);

        for (int i = 0; i < 8; i++) begin
            int code;
            code = int'($urandom_range(0, 11));
            press_release($sformatf("rnd%0d_k%0d", i, code), code, int'($urandom_range(30, 90)), 1'b0);
        end

        check("no_overlap", overlap_err, 0);
        check("strobe_width", width_err, 0);
        check("row_onehot", row_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
